// File: rtl/game_round_ctrl_pkg.sv
// Shared result codes and FSM state encoding for the game round controller.
package game_pkg;

  localparam logic [1:0] RES_PLAY = 2'b00;
  localparam logic [1:0] RES_WIN  = 2'b01;
  localparam logic [1:0] RES_LOSE = 2'b10;
  localparam logic [1:0] RES_ERR  = 2'b11;

  typedef enum logic [1:0] {
    PLAY,
    RESTART,
    OVER
  } st_e;

endpackage

// File: rtl/game_round_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Count is registered, one cycle from inc to update; no backpressure.
module sat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Scores game rounds into a best-of-N match and sequences the game's restart.
// All outputs registered, one cycle after the sampled result; no backpressure.
module game_round_ctrl #(
  parameter int unsigned CW             = 4,
  parameter int unsigned LW             = 8,
  parameter int unsigned TARGET         = 3,
  parameter int unsigned RESTART_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [1:0]    result,
  input  logic          new_match,
  output logic          game_rst,
  output logic          round_done,
  output logic [1:0]    last_result,
  output logic [LW-1:0] round_len,
  output logic [CW-1:0] wins,
  output logic [CW-1:0] losses,
  output logic [CW-1:0] errors,
  output logic          match_over
);
  import game_pkg::*;

  localparam int unsigned     RCW      = $clog2(RESTART_CYCLES + 1);
  localparam logic [RCW-1:0]  RC_LOAD  = RCW'(RESTART_CYCLES);
  localparam logic [CW-1:0]   TGT_LAST = CW'(TARGET - 1);

  st_e            state, state_d;
  logic [RCW-1:0] rst_cnt, rst_cnt_d;
  logic [LW-1:0]  len;
  logic           len_clr, len_inc;
  logic           win_inc, lose_inc, err_inc, clr_scores;
  logic           round_done_d;
  logic [1:0]     last_result_d;
  logic [LW-1:0]  round_len_d;

  sat_counter #(.W(CW)) u_wins (
    .clk(clk), .reset_n(reset_n), .clr(clr_scores), .inc(win_inc), .count(wins)
  );
  sat_counter #(.W(CW)) u_losses (
    .clk(clk), .reset_n(reset_n), .clr(clr_scores), .inc(lose_inc), .count(losses)
  );
  sat_counter #(.W(CW)) u_errors (
    .clk(clk), .reset_n(reset_n), .clr(clr_scores), .inc(err_inc), .count(errors)
  );
  sat_counter #(.W(LW)) u_len (
    .clk(clk), .reset_n(reset_n), .clr(len_clr), .inc(len_inc), .count(len)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RESTART;
      rst_cnt     <= RC_LOAD;
      game_rst    <= 1'b1;
      round_done  <= 1'b0;
      last_result <= '0;
      round_len   <= '0;
      match_over  <= 1'b0;
    end else begin
      state       <= state_d;
      rst_cnt     <= rst_cnt_d;
      game_rst    <= (state_d != PLAY);
      round_done  <= round_done_d;
      last_result <= last_result_d;
      round_len   <= round_len_d;
      match_over  <= (state_d == OVER);
    end
  end

  always_comb begin
    state_d       = state;
    rst_cnt_d     = rst_cnt;
    round_done_d  = 1'b0;
    last_result_d = last_result;
    round_len_d   = round_len;
    len_clr       = 1'b0;
    len_inc       = 1'b0;
    win_inc       = 1'b0;
    lose_inc      = 1'b0;
    err_inc       = 1'b0;
    clr_scores    = 1'b0;

    // A new match request aborts whatever is in flight, including an unscored round.
    if (new_match) begin
      clr_scores = 1'b1;
      state_d    = RESTART;
      rst_cnt_d  = RC_LOAD;
    end else begin
      case (state)
        RESTART: begin
          if (rst_cnt == RCW'(1)) begin
            state_d = PLAY;
            len_clr = 1'b1;
          end else begin
            rst_cnt_d = rst_cnt - RCW'(1);
          end
        end
        PLAY: begin
          if (result == RES_PLAY) begin
            len_inc = 1'b1;
          end else begin
            round_done_d  = 1'b1;
            last_result_d = result;
            round_len_d   = (&len) ? len : len + LW'(1);
            rst_cnt_d     = RC_LOAD;
            state_d       = RESTART;
            case (result)
              RES_WIN: begin
                win_inc = 1'b1;
                if (wins == TGT_LAST) state_d = OVER;
              end
              RES_LOSE: begin
                lose_inc = 1'b1;
                if (losses == TGT_LAST) state_d = OVER;
              end
              default: err_inc = 1'b1;
            endcase
          end
        end
        OVER: state_d = OVER;
        default: begin
          state_d   = RESTART;
          rst_cnt_d = RC_LOAD;
        end
      endcase
    end
  end

endmodule
